// File: rtl/player_motion.sv
// Player sprite motion controller: once per video frame it walks the sprite
// left/right, applies jumps (up to a double jump), gravity and floor/ceiling
// limits. Frame timing comes from the VGA vsync, brought into the clk domain.
//
// state  | meaning
// -------+-----------------------------------------------------------
// GROUND | standing on the floor, y and vy frozen until a jump
// RISE   | airborne with vy < 0 (moving up)
// FALL   | airborne with vy >= 0 (apex or moving down)
module player_motion #(
    parameter int START_X    = 100,
    parameter int FLOOR_Y    = 458,
    parameter int SPRITE_W   = 22,
    parameter int SCREEN_W   = 640,
    parameter int WALK_SPEED = 3,
    parameter int JUMP_V     = 8,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       facing,
    output logic       airborne
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    localparam logic [9:0]         START_U = 10'(START_X);
    localparam logic [9:0]         FLOOR_U = 10'(FLOOR_Y);
    localparam logic [9:0]         WALK_U  = 10'(WALK_SPEED);
    localparam logic [9:0]         X_MAX   = 10'(SCREEN_W - SPRITE_W);
    localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
    localparam logic signed [10:0] JUMP_S  = 11'(JUMP_V);
    localparam logic signed [5:0]  GRAV_S  = 6'(GRAVITY);
    localparam logic signed [5:0]  MAXF_S  = 6'(MAX_FALL);

    logic vsync_s1, vsync_s2, vsync_d;
    logic frame_tick;

    logic jump_d, jump_pending, jump_edge, jump_req, jump_ok;

    state_t            state, state_next;
    logic signed [5:0] vy, vy_next;
    logic [1:0]        jumps_used, jumps_next;
    logic [9:0]        y_next, x_next;
    logic              facing_next, airborne_next;

    logic signed [10:0] vy_eff;
    logic signed [10:0] y_sum;
    logic signed [5:0]  vy_eff6, vy_rise, vy_cap;
    logic [10:0]        x_up;

    // Two-flop synchronizer for vsync plus a delay flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_s1 <= 1'b1;
            vsync_s2 <= 1'b1;
            vsync_d  <= 1'b1;
        end else begin
            vsync_s1 <= vsync;
            vsync_s2 <= vsync_s1;
            vsync_d  <= vsync_s2;
        end
    end

    assign frame_tick = vsync_d & ~vsync_s2;

    // Latch a jump press until the next frame tick consumes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_d       <= 1'b0;
            jump_pending <= 1'b0;
        end else begin
            jump_d <= btn_jump;
            if (frame_tick)
                jump_pending <= 1'b0;
            else if (jump_edge)
                jump_pending <= 1'b1;
        end
    end

    // A press landing in the tick cycle itself is used by that tick
    assign jump_edge = btn_jump & ~jump_d;
    assign jump_req  = jump_pending | jump_edge;
    assign jump_ok   = jump_req && (jumps_used < 2'd2);

    assign vy_eff  = jump_ok ? -JUMP_S
                   : (state == GROUND) ? 11'sd0
                   : {{5{vy[5]}}, vy};
    assign y_sum   = $signed({1'b0, pos_y}) + vy_eff;
    assign vy_eff6 = vy_eff[5:0];
    assign vy_rise = vy_eff6 + GRAV_S;
    assign vy_cap  = (vy_rise > MAXF_S) ? MAXF_S : vy_rise;
    assign x_up    = {1'b0, pos_x} + {1'b0, WALK_U};

    // State and output registers, advanced once per frame tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= GROUND;
            vy         <= 6'sd0;
            jumps_used <= 2'd0;
            pos_x      <= START_U;
            pos_y      <= FLOOR_U;
            facing     <= 1'b0;
            airborne   <= 1'b0;
        end else if (frame_tick) begin
            state      <= state_next;
            vy         <= vy_next;
            jumps_used <= jumps_next;
            pos_x      <= x_next;
            pos_y      <= y_next;
            facing     <= facing_next;
            airborne   <= airborne_next;
        end
    end

    // Vertical next state: jump, gravity, floor landing and ceiling clamp
    always_comb begin
        state_next = state;
        vy_next    = vy;
        jumps_next = jumps_used;
        y_next     = pos_y;
        if (state != GROUND || jump_ok) begin
            jumps_next = jump_ok ? jumps_used + 2'd1 : jumps_used;
            if (y_sum >= FLOOR_S) begin
                y_next     = FLOOR_U;
                vy_next    = 6'sd0;
                jumps_next = 2'd0;
                state_next = GROUND;
            end else if (y_sum[10]) begin
                y_next     = 10'd0;
                vy_next    = 6'sd0;
                state_next = FALL;
            end else begin
                y_next     = y_sum[9:0];
                vy_next    = vy_cap;
                state_next = vy_cap[5] ? RISE : FALL;
            end
        end
    end

    // Horizontal next state and registered-output values
    always_comb begin
        x_next        = pos_x;
        facing_next   = facing;
        airborne_next = (state_next != GROUND);
        if (btn_left && !btn_right) begin
            x_next      = (pos_x < WALK_U) ? 10'd0 : pos_x - WALK_U;
            facing_next = 1'b1;
        end else if (btn_right && !btn_left) begin
            x_next      = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[9:0];
            facing_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: vector table, hand-built corner
// sequences, and a randomized run against a frame-level behavioural model.
module tb_player_motion;

    localparam int START_X  = 100;
    localparam int FLOOR_Y  = 458;
    localparam int X_MAX    = 640 - 22;
    localparam int WALK     = 3;
    localparam int JUMP_V   = 8;
    localparam int GRAVITY  = 1;
    localparam int MAX_FALL = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic [9:0] pos_x, pos_y;
    logic       facing, airborne;

    int errors = 0;
    int checks = 0;

    player_motion dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .facing    (facing),
        .airborne  (airborne)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit l, r, j;
        int x, y;
        bit f, a;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    int m_x, m_y, m_vy, m_jumps, m_face;
    bit m_ground;
    bit prev_j;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit l, r, j, input int x, y, input bit f, a);
        vec_t v;
        v.l = l; v.r = r; v.j = j; v.x = x; v.y = y; v.f = f; v.a = a;
        vecs.push_back(v);
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge
    task automatic do_reset();
        rst = 1'b0;
        vsync = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        prev_j = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One video frame: vsync low for 3 clocks, high for 3, buttons held throughout
    task automatic frame(input bit l, input bit r, input bit j);
        btn_left = l; btn_right = r; btn_jump = j;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = START_X; m_y = FLOOR_Y; m_vy = 0; m_jumps = 0;
        m_face = 0; m_ground = 1'b1;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit jedge);
        int veff, yn;
        bit ok;
        if (l && !r) begin
            m_x = (m_x - WALK < 0) ? 0 : m_x - WALK;
            m_face = 1;
        end else if (r && !l) begin
            m_x = (m_x + WALK > X_MAX) ? X_MAX : m_x + WALK;
            m_face = 0;
        end
        ok = jedge && (m_jumps < 2);
        if (!m_ground || ok) begin
            veff = ok ? -JUMP_V : (m_ground ? 0 : m_vy);
            if (ok) m_jumps++;
            yn = m_y + veff;
            if (yn >= FLOOR_Y) begin
                m_y = FLOOR_Y; m_vy = 0; m_jumps = 0; m_ground = 1'b1;
            end else if (yn < 0) begin
                m_y = 0; m_vy = 0; m_ground = 1'b0;
            end else begin
                m_y = yn;
                m_vy = (veff + GRAVITY > MAX_FALL) ? MAX_FALL : veff + GRAVITY;
                m_ground = 1'b0;
            end
        end
    endtask

    initial begin
        // Walking, both/neither buttons, single jump arc, double jump, third press
        add(0,1,0, 103,458,0,0);
        add(0,1,0, 106,458,0,0);
        add(0,1,0, 109,458,0,0);
        add(1,1,0, 109,458,0,0);
        add(1,0,0, 106,458,1,0);
        add(1,1,0, 106,458,1,0);
        add(0,0,0, 106,458,1,0);
        add(0,0,1, 106,450,1,1);
        add(0,1,1, 109,443,0,1);
        add(0,0,0, 109,437,0,1);
        add(0,0,0, 109,432,0,1);
        add(0,0,0, 109,428,0,1);
        add(0,0,0, 109,425,0,1);
        add(0,0,0, 109,423,0,1);
        add(0,0,0, 109,422,0,1);
        add(0,0,0, 109,422,0,1);
        add(0,0,0, 109,423,0,1);
        add(0,0,0, 109,425,0,1);
        add(0,0,0, 109,428,0,1);
        add(0,0,0, 109,432,0,1);
        add(0,0,0, 109,437,0,1);
        add(0,0,0, 109,443,0,1);
        add(0,0,0, 109,450,0,1);
        add(0,0,0, 109,458,0,0);
        add(0,0,0, 109,458,0,0);
        add(0,0,1, 109,450,0,1);
        add(0,0,0, 109,443,0,1);
        add(0,0,0, 109,437,0,1);
        add(0,0,1, 109,429,0,1);
        add(0,0,0, 109,422,0,1);
        add(0,0,1, 109,416,0,1);
        add(0,0,0, 109,411,0,1);

        @(posedge clk);
        #1;
        do_reset();
        chk("reset_x", int'(pos_x), START_X);
        chk("reset_y", int'(pos_y), FLOOR_Y);
        chk("reset_facing", int'(facing), 0);
        chk("reset_airborne", int'(airborne), 0);

        foreach (vecs[i]) begin
            frame(vecs[i].l, vecs[i].r, vecs[i].j);
            chk($sformatf("vec%0d_x", i), int'(pos_x), vecs[i].x);
            chk($sformatf("vec%0d_y", i), int'(pos_y), vecs[i].y);
            chk($sformatf("vec%0d_facing", i), int'(facing), int'(vecs[i].f));
            chk($sformatf("vec%0d_airborne", i), int'(airborne), int'(vecs[i].a));
        end

        // Jump edge arriving in the tick cycle; outputs held until after the tick edge
        do_reset();
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 btn_jump = 1'b1;
        chk("coincident_before_tick_y", int'(pos_y), FLOOR_Y);
        @(posedge clk);
        #1;
        chk("coincident_after_tick_y", int'(pos_y), 450);
        chk("coincident_after_tick_air", int'(airborne), 1);
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Left wall clamp
        do_reset();
        repeat (33) frame(1, 0, 0);
        chk("left_wall_x1", int'(pos_x), 1);
        frame(1, 0, 0);
        chk("left_wall_x0", int'(pos_x), 0);
        frame(1, 0, 0);
        chk("left_wall_stay", int'(pos_x), 0);
        chk("left_wall_facing", int'(facing), 1);

        // Right wall clamp with a partial final step
        do_reset();
        repeat (172) frame(0, 1, 0);
        chk("right_wall_x616", int'(pos_x), 616);
        frame(0, 1, 0);
        chk("right_wall_x618", int'(pos_x), X_MAX);
        frame(0, 1, 0);
        chk("right_wall_stay", int'(pos_x), X_MAX);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int t = 0; t < 300; t++) begin
            bit l, r, j, e;
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 2) == 0);
            e = j && !prev_j;
            prev_j = j;
            frame(l, r, j);
            model_tick(l, r, e);
            chk($sformatf("rand%0d_x", t), int'(pos_x), m_x);
            chk($sformatf("rand%0d_y", t), int'(pos_y), m_y);
            chk($sformatf("rand%0d_facing", t), int'(facing), m_face);
            chk($sformatf("rand%0d_airborne", t), int'(airborne), int'(!m_ground));
        end

        // Asynchronous reset in mid-jump
        do_reset();
        frame(0, 1, 1);
        frame(0, 0, 0);
        frame(0, 0, 0);
        frame(0, 0, 0);
        chk("midjump_y", int'(pos_y), 432);
        chk("midjump_x", int'(pos_x), 103);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_x", int'(pos_x), START_X);
        chk("async_rst_y", int'(pos_y), FLOOR_Y);
        chk("async_rst_airborne", int'(airborne), 0);
        chk("async_rst_facing", int'(facing), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
